// File: rtl/reg_bank_pkg.sv
// Shared types for the register bank readback path.
// Response entry layout, occupancy states and counter limits.
package reg_bank_pkg;

  localparam int DATA_W_DEF = 16;
  localparam logic [15:0] COUNT_MAX = 16'hFFFF;

  typedef struct packed {
    logic                  err;
    logic [DATA_W_DEF-1:0] data;
  } rsp_entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/reg_bank_reader_rsp_fifo2.sv
// Two-entry in-order response buffer.
// Occupancy is tracked as an explicit EMPTY/ONE/FULL state.
module rsp_fifo2
  import reg_bank_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       push,
  input  logic       pop,
  input  rsp_entry_t wr_entry,
  output logic       full,
  output logic       empty,
  output rsp_entry_t head
);

  occ_e       state_q, state_d;
  rsp_entry_t mem_q [2];
  rsp_entry_t mem_d [2];
  logic       rd_q, rd_d;
  logic       wr_q, wr_d;
  logic       do_push;
  logic       do_pop;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= EMPTY;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      rd_q     <= rd_d;
      wr_q     <= wr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mem_d[0] = mem_q[0];
    mem_d[1] = mem_q[1];
    rd_d     = rd_q;
    wr_d     = wr_q;
    do_push  = push && (state_q != FULL);
    do_pop   = pop && (state_q != EMPTY);

    if (do_push) begin
      mem_d[wr_q] = wr_entry;
      wr_d        = ~wr_q;
    end
    if (do_pop) begin
      rd_d = ~rd_q;
    end

    unique case (state_q)
      EMPTY: begin
        if (do_push) state_d = ONE;
      end
      ONE: begin
        if (do_push && !do_pop) state_d = FULL;
        else if (do_pop && !do_push) state_d = EMPTY;
      end
      FULL: begin
        if (do_pop) state_d = ONE;
      end
      default: state_d = EMPTY;
    endcase
  end

  assign full  = (state_q == FULL);
  assign empty = (state_q == EMPTY);
  // Idle outputs are forced to zero rather than exposing stale storage.
  assign head  = empty ? '0 : mem_q[rd_q];

endmodule

// File: rtl/reg_bank_reader.sv
// Readback port for the 16-bit register bank.
// Samples one register per accepted request into a 2-deep response buffer.
module reg_bank_reader
  import reg_bank_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [NUM_REGS*DATA_W-1:0] REGS_IN,
  input  logic                       req_valid,
  input  logic [ADDR_W-1:0]          req_addr,
  output logic                       req_ready,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_W-1:0]          rsp_data,
  output logic                       rsp_err,
  output logic [15:0]                rsp_count
);

  localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);

  logic              fifo_full;
  logic              fifo_empty;
  rsp_entry_t        head;
  rsp_entry_t        entry;
  logic              accept;
  logic              pop;
  logic              in_range;
  logic [DATA_W-1:0] reg_sel;
  logic [15:0]       count_q, count_d;

  assign req_ready = !fifo_full;
  assign rsp_valid = !fifo_empty;
  assign accept    = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;
  assign in_range  = {1'b0, req_addr} < NUM_REGS_W;

  always_comb begin
    reg_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (req_addr == ADDR_W'(i)) begin
        reg_sel = REGS_IN[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    entry = '0;
    if (in_range) begin
      entry.data = reg_sel;
    end else begin
      entry.err = 1'b1;
    end
  end

  rsp_fifo2 u_fifo (
    .CLK      (CLK),
    .RST      (RST),
    .push     (accept),
    .pop      (pop),
    .wr_entry (entry),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (head)
  );

  assign rsp_data = head.data;
  assign rsp_err  = head.err;

  always_comb begin
    count_d = count_q;
    if (pop && (count_q != COUNT_MAX)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign rsp_count = count_q;

endmodule

// File: tb/tb_reg_bank_reader.sv
// Directed bench for reg_bank_reader.
// Inputs change on the falling edge; outputs are checked there too.
module tb_reg_bank_reader;

  logic         CLK;
  logic         RST;
  logic [127:0] regs_in;
  logic         req_valid;
  logic [3:0]   req_addr;
  logic         req_ready;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [15:0]  rsp_data;
  logic         rsp_err;
  logic [15:0]  rsp_count;

  logic [15:0]  bank [8];
  int           n_tests;
  int           n_fail;

  always_comb begin
    for (int i = 0; i < 8; i++) regs_in[i*16 +: 16] = bank[i];
  end

  reg_bank_reader dut (
    .CLK       (CLK),
    .RST       (RST),
    .REGS_IN   (regs_in),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .rsp_count (rsp_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    logic [15:0] exp_s [8];
    int pops;
    int cyc;
    n_tests   = 0;
    n_fail    = 0;
    RST       = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 8; i++) bank[i] = 16'h0;

    // reset state
    @(negedge CLK);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_count", rsp_count, 0);
    RST = 1'b0;

    // single read
    @(negedge CLK);
    bank[3]   = 16'hBEEF;
    req_valid = 1'b1;
    req_addr  = 4'd3;
    @(negedge CLK);
    req_valid = 1'b0;
    chk("single_valid", rsp_valid, 1);
    chk("single_data", rsp_data, 16'hBEEF);
    chk("single_err", rsp_err, 0);
    rsp_ready = 1'b1;
    @(negedge CLK);
    chk("single_empty", rsp_valid, 0);
    chk("single_count", rsp_count, 1);
    chk("empty_data", rsp_data, 0);
    rsp_ready = 1'b0;

    // out of range
    req_valid = 1'b1;
    req_addr  = 4'd9;
    @(negedge CLK);
    req_valid = 1'b0;
    chk("oor_valid", rsp_valid, 1);
    chk("oor_err", rsp_err, 1);
    chk("oor_data", rsp_data, 0);
    rsp_ready = 1'b1;
    @(negedge CLK);
    chk("oor_count", rsp_count, 2);
    chk("oor_err_clr", rsp_err, 0);
    rsp_ready = 1'b0;

    // backpressure
    bank[0]   = 16'hA000;
    bank[1]   = 16'hA001;
    bank[2]   = 16'hA002;
    req_valid = 1'b1;
    req_addr  = 4'd0;
    @(negedge CLK);
    chk("bp_ready_one", req_ready, 1);
    req_addr = 4'd1;
    @(negedge CLK);
    chk("bp_ready_full", req_ready, 0);
    chk("bp_head0", rsp_data, 16'hA000);
    req_addr = 4'd2;
    @(negedge CLK);
    chk("bp_still_full", req_ready, 0);
    chk("bp_stall_data", rsp_data, 16'hA000);
    chk("bp_stall_valid", rsp_valid, 1);
    rsp_ready = 1'b1;
    @(negedge CLK);
    chk("bp_head1", rsp_data, 16'hA001);
    chk("bp_ready_again", req_ready, 1);
    @(negedge CLK);
    req_valid = 1'b0;
    chk("bp_head2", rsp_data, 16'hA002);
    chk("bp_valid2", rsp_valid, 1);
    @(negedge CLK);
    chk("bp_drained", rsp_valid, 0);
    chk("bp_count", rsp_count, 5);

    // streaming with a same-edge bank write on reg5
    for (int i = 0; i < 8; i++) begin
      bank[i]  = 16'h1000 + 16'(i);
      exp_s[i] = 16'h1000 + 16'(i);
    end
    bank[5]  = 16'h1111;
    exp_s[5] = 16'h1111;
    req_valid = 1'b1;
    req_addr  = 4'd0;
    for (int k = 0; k < 8; k++) begin
      @(posedge CLK);
      if (k == 5) begin
        #1 bank[5] = 16'h2222;
      end
      @(negedge CLK);
      chk($sformatf("stream_data%0d", k), rsp_data, exp_s[k]);
      chk($sformatf("stream_rdy%0d", k), req_ready, 1);
      if (k < 7) req_addr = 4'(k + 1);
      else req_valid = 1'b0;
    end
    @(negedge CLK);
    chk("stream_drained", rsp_valid, 0);
    chk("stream_count", rsp_count, 13);

    // reset with two buffered responses
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_addr  = 4'd1;
    @(negedge CLK);
    req_addr = 4'd2;
    @(negedge CLK);
    req_valid = 1'b0;
    chk("mid_full", req_ready, 0);
    RST = 1'b1;
    #1;
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_ready", req_ready, 1);
    chk("mid_rst_count", rsp_count, 0);
    @(negedge CLK);
    RST       = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk($sformatf("no_stale%0d", k), rsp_valid, 0);
    end
    chk("post_rst_count", rsp_count, 0);

    // saturation after 65537 pops
    req_valid = 1'b1;
    req_addr  = 4'd4;
    pops = 0;
    cyc  = 0;
    while (pops < 65537 && cyc < 70000) begin
      @(negedge CLK);
      cyc++;
      if (rsp_valid) pops++;
    end
    chk("sat_budget", pops, 65537);
    req_valid = 1'b0;
    @(negedge CLK);
    chk("sat_drained", rsp_valid, 0);
    chk("sat_count", rsp_count, 16'hFFFF);
    req_valid = 1'b1;
    req_addr  = 4'd10;
    @(negedge CLK);
    req_valid = 1'b0;
    chk("sat_extra_err", rsp_err, 1);
    @(negedge CLK);
    chk("sat_hold", rsp_count, 16'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_bank_reader.md
Name: reg_bank_reader

Overview:
- Read-side companion to the team's 16-bit write-enabled register bank.
- Takes read requests (register index) over a valid/ready channel and samples the flattened register bank contents.
- Returns each word, or an error for an out-of-range index, over a valid/ready response channel.
- Sits between the register bank and any bus/debug master that needs readback; buffers up to 2 outstanding responses so a master can pipeline requests.

Parameters:
- NUM_REGS, 8, number of 16-bit registers presented on REGS_IN (1..2**ADDR_W).
- DATA_W, 16, register width in bits.
- ADDR_W, 4, request index width; indices >= NUM_REGS are out of range.

Ports:
- CLK  input  1  clock, all state updates on rising edge.
- RST  input  1  reset, asynchronous, active-high.
- REGS_IN  input  NUM_REGS*DATA_W  flattened bank; register i = REGS_IN[i*DATA_W +: DATA_W].
- req_valid  input  1  request present.
- req_addr  input  ADDR_W  register index to read.
- req_ready  output  1  block can accept a request this cycle.
- rsp_valid  output  1  response at head of buffer.
- rsp_ready  input  1  consumer takes response this cycle.
- rsp_data  output  DATA_W  read data of head response.
- rsp_err  output  1  head response was out of range.
- rsp_count  output  16  number of responses consumed, saturating.

Behaviour:
- Reset: RST=1 asynchronously clears the buffer to EMPTY and clears both entries and rsp_count.
  - Outputs during/after reset: req_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, rsp_count=0.
- Reset mid-operation: pending responses are discarded and never emitted.
- Accept: a request is accepted on a rising edge with req_valid=1 and req_ready=1.
- Sampling:
  - REGS_IN is sampled on the accepting edge only.
  - Later bank changes do not affect a buffered response.
  - A bank write on the same edge is not seen; the old value is returned.
- In-range index (req_addr < NUM_REGS): entry = {err=0, data=register[req_addr]}.
- Out-of-range index: entry = {err=1, data=0}.
- Latency: exactly 1 cycle. A request accepted at edge N produces rsp_valid=1 from edge N onward when the buffer was empty; no combinational req->rsp path.
- Buffer: 2-entry FIFO with strict in-order responses. Occupancy FSM:
  - EMPTY -> ONE on push.
  - ONE -> FULL on push without pop.
  - ONE -> EMPTY on pop without push.
  - ONE -> ONE on simultaneous push+pop: head advances, new entry becomes head.
  - FULL -> ONE on pop. Push is impossible in FULL.
- req_ready = (state != FULL). It is registered-state derived and never depends on rsp_ready in the same cycle. Consequence: no accept in a cycle that starts FULL, even if a pop happens that cycle.
- Pop occurs when rsp_valid=1 and rsp_ready=1.
- rsp_valid = (state != EMPTY).
- Stall: while rsp_valid=1 and rsp_ready=0, rsp_data and rsp_err hold stable.
- Empty outputs: when rsp_valid=0, rsp_data=0 and rsp_err=0.
- rsp_count: increments by 1 on each pop, including error responses; saturates at 16'hFFFF without wrapping.
- req_addr and REGS_IN are don't-care when req_valid=0.
- Throughput: 1 request/cycle sustained while rsp_ready=1.

Decomposition:
- Package reg_bank_pkg:
  - DATA_W_DEF=16 and COUNT_MAX=16'hFFFF constants.
  - Response entry typedef {logic err; logic [15:0] data}.
  - Occupancy enum {EMPTY, ONE, FULL}.
- Sub-module rsp_fifo2: 2-entry FIFO with push/pop/full/empty and head output, instantiated once.
- Top level holds the index decode and range check, the bank slice mux and rsp_count.

Test Plan:
- Reset then idle: RST pulse mid-stream with 2 entries buffered -> rsp_valid=0, req_ready=1, rsp_count=0, no stale response after release.
- Single read: REGS_IN reg3=16'hBEEF, req addr 3 accepted at edge N -> rsp_valid=1 after edge N, rsp_data=16'hBEEF, rsp_err=0; pop -> rsp_count=1.
- Out of range: req addr 9 (NUM_REGS=8) -> rsp_err=1, rsp_data=0; rsp_count still increments on pop.
- Backpressure: rsp_ready=0, requests to addr 0,1,2 back-to-back -> only 2 accepted, req_ready=0 while FULL; rsp_data stays on reg0 value. Raise rsp_ready -> reg0, reg1 in order, then addr 2 accepted.
- Streaming with sampling: rsp_ready=1, requests addr 0..7 on consecutive cycles while bank reg5 changes from 16'h1111 to 16'h2222 on the edge that accepts addr 5 -> one response/cycle in order, reg5 response = 16'h1111.
- Saturation: force 65537 pops -> rsp_count=16'hFFFF, stays there.
